// File: rtl/iir_filter_datapath_pkg.sv
// Shared constants for the recursive filter datapath and its control FSM:
// guard-FSM state codes, MAC term indices and default arithmetic widths.
package iir_filter_datapath_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [1:0] TERM_X0 = 2'd0;
  localparam logic [1:0] TERM_X1 = 2'd1;
  localparam logic [1:0] TERM_Y1 = 2'd2;
  localparam logic [1:0] TERM_Y2 = 2'd3;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_COEF_W = 12;
  localparam int DEF_FRAC   = 10;
  localparam int GUARD_W    = 2;

endpackage

// File: rtl/iir_filter_datapath_if.sv
// Control-FSM <-> filter-datapath bus: sample strobe, term select, commit pulse
// and the filtered result with its status flags.
interface iir_filter_datapath_if #(
  parameter int DATA_W = 12
);
  logic                     inicio;
  logic signed [DATA_W-1:0] x_in;
  logic [1:0]               sel;
  logic                     listo;
  logic signed [DATA_W-1:0] y_out;
  logic                     y_valid;
  logic                     busy;
  logic                     seq_err;

  modport master (
    output inicio, x_in, sel, listo,
    input  y_out, y_valid, busy, seq_err
  );

  modport slave (
    input  inicio, x_in, sel, listo,
    output y_out, y_valid, busy, seq_err
  );
endinterface

// File: rtl/iir_filter_datapath_sat_shift.sv
// Combinational requantiser: arithmetic right shift (floor) of a wide signed
// accumulator followed by saturation to a DATA_W signed sample.
module iir_filter_datapath_sat_shift #(
  parameter int ACC_W  = 26,
  parameter int DATA_W = 12,
  parameter int FRAC   = 10
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  function automatic logic signed [ACC_W-1:0] shr(input logic signed [ACC_W-1:0] v);
    shr = v >>> FRAC;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    lo = $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});
    if (v > hi)
      sat = $signed(hi[DATA_W-1:0]);
    else if (v < lo)
      sat = $signed(lo[DATA_W-1:0]);
    else
      sat = $signed(v[DATA_W-1:0]);
  endfunction

  assign y = sat(shr(acc));

endmodule

// File: rtl/iir_filter_datapath.sv
// Recursive filter datapath: y = A0*x0 + A1*x1 + B1*y1 + B2*y2 evaluated one
// MAC per clock, committed on listo, with a guard FSM flagging protocol faults.
module iir_filter_datapath
  import iir_filter_datapath_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int A0     = 512,
  parameter int A1     = 256,
  parameter int B1     = 256,
  parameter int B2     = 0
) (
  input  logic                  clock150kHz,
  input  logic                  reset,
  iir_filter_datapath_if.slave  bus
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + GUARD_W;

  localparam logic signed [COEF_W-1:0] C_A0 = COEF_W'(A0);
  localparam logic signed [COEF_W-1:0] C_A1 = COEF_W'(A1);
  localparam logic signed [COEF_W-1:0] C_B1 = COEF_W'(B1);
  localparam logic signed [COEF_W-1:0] C_B2 = COEF_W'(B2);

  logic [1:0]               state;
  logic [1:0]               k;
  logic signed [DATA_W-1:0] x0, x1, y1, y2;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [DATA_W-1:0] y_out_r;
  logic                     y_valid_r;
  logic                     seq_err_r;

  logic signed [COEF_W-1:0] coef_p0;
  logic signed [DATA_W-1:0] opnd_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  prod_ext_p0;
  logic signed [DATA_W-1:0] r_p2;
  logic                     err_sel, err_listo, err_inicio;

  // Stage p0: term mux steered by the internal counter, never by sel
  always_comb begin
    coef_p0 = C_A0;
    opnd_p0 = x0;
    case (k)
      TERM_X0: begin coef_p0 = C_A0; opnd_p0 = x0; end
      TERM_X1: begin coef_p0 = C_A1; opnd_p0 = x1; end
      TERM_Y1: begin coef_p0 = C_B1; opnd_p0 = y1; end
      TERM_Y2: begin coef_p0 = C_B2; opnd_p0 = y2; end
      default: begin coef_p0 = C_A0; opnd_p0 = x0; end
    endcase
  end

  assign prod_p0 = $signed({{COEF_W{opnd_p0[DATA_W-1]}}, opnd_p0})
                 * $signed({{DATA_W{coef_p0[COEF_W-1]}}, coef_p0});
  assign prod_ext_p0 = $signed({{GUARD_W{prod_p0[PROD_W-1]}}, prod_p0});

  // Stage p2: requantise the accumulator for commit
  iir_filter_datapath_sat_shift #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC   (FRAC)
  ) u_sat_shift (
    .acc (acc_p1),
    .y   (r_p2)
  );

  assign err_sel    = (state == ST_MAC) && (bus.sel != k);
  assign err_listo  = bus.listo && ((state == ST_IDLE) || (state == ST_MAC));
  assign err_inicio = bus.inicio && ((state == ST_MAC) || (state == ST_WAIT));

  // Stage p1: accumulator, history and guard FSM
  always_ff @(posedge clock150kHz or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      k         <= 2'd0;
      acc_p1    <= '0;
      x0        <= '0;
      x1        <= '0;
      y1        <= '0;
      y2        <= '0;
      y_out_r   <= '0;
      y_valid_r <= 1'b0;
      seq_err_r <= 1'b0;
    end else begin
      y_valid_r <= 1'b0;
      if (err_sel || err_listo || err_inicio)
        seq_err_r <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.inicio) begin
            x0     <= bus.x_in;
            acc_p1 <= '0;
            k      <= 2'd0;
            state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_p1 <= acc_p1 + prod_ext_p0;
          k      <= k + 2'd1;
          if (k == TERM_Y2)
            state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.listo) begin
            y_out_r   <= r_p2;
            y1        <= r_p2;
            y2        <= y1;
            x1        <= x0;
            y_valid_r <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.y_out   = y_out_r;
  assign bus.y_valid = y_valid_r;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.seq_err = seq_err_r;

endmodule

// File: tb/tb_iir_filter_datapath.sv
// Directed bench for iir_filter_datapath: a default-coefficient instance and a
// saturation instance (A0=2047, others 0) share one control-FSM-style stimulus.
module tb_iir_filter_datapath;

  logic clock150kHz;
  logic reset;

  iir_filter_datapath_if #(.DATA_W(12)) bus ();
  iir_filter_datapath_if #(.DATA_W(12)) bus_s ();

  assign bus_s.inicio = bus.inicio;
  assign bus_s.x_in   = bus.x_in;
  assign bus_s.sel    = bus.sel;
  assign bus_s.listo  = bus.listo;

  iir_filter_datapath dut (
    .clock150kHz (clock150kHz),
    .reset       (reset),
    .bus         (bus.slave)
  );

  iir_filter_datapath #(
    .A0 (2047), .A1 (0), .B1 (0), .B2 (0)
  ) dut_sat (
    .clock150kHz (clock150kHz),
    .reset       (reset),
    .bus         (bus_s.slave)
  );

  initial clock150kHz = 1'b0;
  always #5 clock150kHz = ~clock150kHz;

  int n_cmp = 0;
  int n_err = 0;
  logic signed [11:0] y_last;
  logic signed [11:0] y_sat_last;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock150kHz);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One sample as the control FSM would sequence it: inicio, four MAC
  // cycles with sel=0..3 (or stuck at 0), then listo; y_valid lands 6 cycles on.
  task automatic do_sample(input logic signed [11:0] x, input bit stuck,
                           input bit stray, input logic signed [11:0] xs);
    bus.inicio = 1'b1;
    bus.x_in   = x;
    tick();
    bus.inicio = 1'b0;
    bus.x_in   = 12'sd0;
    check("vld_single_cycle", bus.y_valid, 0);
    check("busy_mac", bus.busy, 1);
    for (int i = 0; i < 4; i++) begin
      bus.sel = stuck ? 2'd0 : 2'(i);
      tick();
    end
    bus.sel = 2'd0;
    check("vld_before_listo", bus.y_valid, 0);
    check("busy_wait", bus.busy, 1);
    bus.listo = 1'b1;
    if (stray) begin
      bus.inicio = 1'b1;
      bus.x_in   = xs;
    end
    tick();
    bus.listo  = 1'b0;
    bus.inicio = 1'b0;
    bus.x_in   = 12'sd0;
    check("vld_after_listo", bus.y_valid, 1);
    check("idle_after_commit", bus.busy, 0);
    y_last     = bus.y_out;
    y_sat_last = bus_s.y_out;
  endtask

  initial begin
    int x1m, y1m, ym, ymax;
    reset      = 1'b1;
    bus.inicio = 1'b0;
    bus.x_in   = 12'sd0;
    bus.sel    = 2'd0;
    bus.listo  = 1'b0;
    tick();
    check("rst_y_out", bus.y_out, 0);
    check("rst_y_valid", bus.y_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_seq_err", bus.seq_err, 0);
    reset = 1'b0;
    tick();

    // Impulse response with default coefficients
    do_sample(12'sd1000, 0, 0, 12'sd0);
    check("imp_y0", y_last, 500);
    do_sample(12'sd0, 0, 0, 12'sd0);
    check("imp_y1", y_last, 375);
    do_sample(12'sd0, 0, 0, 12'sd0);
    check("imp_y2", y_last, 93);
    tick();
    check("imp_vld_low", bus.y_valid, 0);
    check("imp_seq_err", bus.seq_err, 0);

    // DC step: floor bias settles one LSB under the input, never above it
    do_reset();
    x1m = 0; y1m = 0; ymax = -10000;
    for (int n = 0; n < 20; n++) begin
      do_sample(12'sd400, 0, 0, 12'sd0);
      ym = (512 * 400 + 256 * x1m + 256 * y1m) >>> 10;
      check("dc_y", y_last, ym);
      if (int'(y_last) > ymax) ymax = int'(y_last);
      x1m = 400;
      y1m = ym;
    end
    check("dc_final", y_last, 399);
    check("dc_no_overshoot", (ymax <= 400) ? 1 : 0, 1);
    check("dc_seq_err", bus.seq_err, 0);

    // Saturation instance; default instance shows floor toward -inf
    do_reset();
    do_sample(12'sd2047, 0, 0, 12'sd0);
    check("sat_pos", y_sat_last, 2047);
    check("dflt_2047", y_last, 1023);
    do_sample(-12'sd2048, 0, 0, 12'sd0);
    check("sat_neg", y_sat_last, -2048);
    check("dflt_floor_neg", y_last, -257);

    // sel stuck at 0 during MAC
    do_reset();
    do_sample(12'sd1000, 1, 0, 12'sd0);
    check("stuck_result", y_last, 500);
    check("stuck_seq_err", bus.seq_err, 1);

    // Stray listo in IDLE
    do_reset();
    bus.listo = 1'b1;
    tick();
    bus.listo = 1'b0;
    check("stray_listo_vld", bus.y_valid, 0);
    check("stray_listo_err", bus.seq_err, 1);
    check("stray_listo_y", bus.y_out, 0);
    tick();
    check("stray_listo_vld2", bus.y_valid, 0);

    // Reset asserted asynchronously inside the MAC phase
    do_reset();
    do_sample(12'sd1000, 0, 0, 12'sd0);
    check("pre_rst_y", y_last, 500);
    bus.inicio = 1'b1;
    bus.x_in   = 12'sd1000;
    tick();
    bus.inicio = 1'b0;
    bus.sel    = 2'd0;
    tick();
    bus.sel = 2'd1;
    tick();
    bus.sel = 2'd2;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_y_out", bus.y_out, 0);
    check("midrst_y_valid", bus.y_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_seq_err", bus.seq_err, 0);
    tick();
    reset   = 1'b0;
    bus.sel = 2'd0;
    tick();
    do_sample(12'sd1000, 0, 0, 12'sd0);
    check("post_rst_y", y_last, 500);
    check("post_rst_err", bus.seq_err, 0);

    // inicio in the listo cycle is ignored; one cycle later it is accepted
    do_reset();
    do_sample(12'sd1000, 0, 0, 12'sd0);
    check("b2b_a", y_last, 500);
    check("b2b_err_clear", bus.seq_err, 0);
    do_sample(12'sd0, 0, 1, 12'sd2000);
    check("b2b_b", y_last, 375);
    check("b2b_err_set", bus.seq_err, 1);
    do_sample(12'sd0, 0, 0, 12'sd0);
    check("b2b_c", y_last, 93);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
